multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: resetPC  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs: opcode 7 (instr[6:0]); funct3 3 (instr[14:12]); funct7b5 1 (instr[30]); zero 1 (ALU zero flag); mem_ready 1 (shared memory access completes this cycle).
REQ-004 SHALL have 1-bit outputs: PCWrite; PCSrc (0 = PC+4 adder, 1 = ALUOut); IRWrite (latches IR and OldPC); IorD (memory address: 0 = PC, 1 = ALUOut); ASel (0 = rs1, 1 = OldPC); RegWEn; MEMRead; MEMWrite; illegal; retire.
REQ-005 SHALL have outputs: BSel 2 (00 rs2, 01 imm, 10 const 4); ALUSel 4; WBSel 2 (00 ALUOut, 01 mem data, 10 PC); state_dbg 3; instret 32.

Function
REQ-006 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state_dbg = current state.
REQ-007 Outputs SHALL be combinational from state, decoded fields, zero and mem_ready; unlisted strobes are 0 and unlisted selects are 0.
REQ-008 FETCH: MEMRead=1, IorD=0; while mem_ready=0, remain with no other strobe; when mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
REQ-009 DECODE: ASel=1, BSel=01, ALUSel=ADD (branch/JAL target into ALUOut); go to EXEC for legal instructions and to TRAP otherwise.
REQ-010 Legal set: R-type 0110011; I-ALU 0010011; LW 0000011 with funct3=010; SW 0100011 with funct3=010; BEQ/BNE 1100011 with funct3 000/001; JAL 1101111.
REQ-011 EXEC R-type: ASel=0, BSel=00, ALUSel from funct3 and funct7b5; go to WB.
REQ-012 EXEC I-ALU: BSel=01; funct7b5 is used only when funct3=101 (SRAI); funct3=000 is always ADD; go to WB.
REQ-013 EXEC LW/SW: BSel=01, ALUSel=ADD; go to MEM.
REQ-014 EXEC branch: BSel=00, ALUSel=SUB; taken = zero (BEQ) or !zero (BNE); if taken, PCWrite=1 and PCSrc=1; retire=1; go to FETCH.
REQ-015 EXEC JAL: PCWrite=1, PCSrc=1; go to WB.
REQ-016 MEM LW: MEMRead=1, IorD=1; wait on mem_ready; go to WB. MEM SW: MEMWrite=1, IorD=1; wait on mem_ready; retire=1 on the completing cycle; go to FETCH.
REQ-017 WB: RegWEn=1; WBSel=01 for LW, 10 for JAL, 00 otherwise; retire=1; go to FETCH.
REQ-018 TRAP: illegal=1 and all strobes 0; exit only via reset.
REQ-019 Zero-wait latency SHALL be: branch 3 cycles; R-type, I-ALU, SW and JAL 4 cycles; LW 5 cycles. Each mem_ready=0 cycle adds exactly one cycle.
REQ-020 instret SHALL increment by 1 on each cycle with retire=1 and wrap from 0xFFFFFFFF to 0.
REQ-021 ALUSel codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.

Reset
REQ-022 While resetPC=1, all strobe outputs SHALL be 0, and on the next edge state SHALL become FETCH and instret SHALL become 0.
REQ-023 Reset asserted mid-instruction, including during a mem_ready wait, SHALL abort it with no retire, PCWrite or RegWEn in that cycle.

Structure
REQ-024 Package riscv_ctrl_pkg SHALL hold the state encoding, opcode constants, ALUSel codes, and BSel/WBSel codes.
REQ-025 The block SHALL contain one combinational sub-module, alu_decoder (opcode class, funct3, funct7b5 -> ALUSel).

Verification
REQ-026 Reset, then R-type SUB (opcode 0110011, funct3 000, b5=1), mem_ready=1 -> states 0,1,2,4,0; ALUSel=0001 in EXEC; RegWEn=1 only in WB; instret=1.
REQ-027 LW with mem_ready low for 2 cycles in both FETCH and MEM -> 9 cycles total; WBSel=01 in WB.
REQ-028 BEQ with zero=1, then BEQ with zero=0 -> PCWrite with PCSrc=1 only in the first EXEC; each takes 3 cycles.
REQ-029 Opcode 1111111 -> TRAP after DECODE; illegal=1 held for 10 cycles with no strobes; resetPC pulse -> FETCH.
REQ-030 instret preloaded to 0xFFFFFFFF via force, then one SW -> instret=0; resetPC asserted during a MEM wait -> no MEMWrite in the reset cycle, then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// instruction classes, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned ALUSEL_W  = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_IALU   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [FUNCT3_W-1:0] F3_WORD = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [ALUSEL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUSEL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALUSEL_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [ALUSEL_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [ALUSEL_W-1:0] ALU_SLTU = 4'b0100;
    localparam logic [ALUSEL_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [ALUSEL_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALUSEL_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALUSEL_W-1:0] ALU_OR   = 4'b1000;
    localparam logic [ALUSEL_W-1:0] ALU_AND  = 4'b1001;

    localparam logic [SEL_W-1:0] BSEL_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] BSEL_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] BSEL_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] WBSEL_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WBSEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WBSEL_PC  = 2'b10;

    // Map opcode/funct3 onto the supported instruction classes; anything else traps.
    function automatic op_class_e classify(input logic [OPCODE_W-1:0] opcode,
                                           input logic [FUNCT3_W-1:0] funct3);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        unique case (opcode)
            OPC_RTYPE:  cls = CLS_R;
            OPC_IALU:   cls = CLS_I;
            OPC_LOAD:   if (funct3 == F3_WORD) cls = CLS_LOAD;
            OPC_STORE:  if (funct3 == F3_WORD) cls = CLS_STORE;
            OPC_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select from instruction class and function bits (purely combinational).
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  op_class_e             op_class_i,
    input  logic [FUNCT3_W-1:0]   funct3_i,
    input  logic                  funct7b5_i,
    output logic [ALUSEL_W-1:0]   alu_sel_o
);

    logic [ALUSEL_W-1:0] arith_sel;

    // Shared R/I-type table; the SUB/SRA distinction is resolved below.
    always_comb begin
        arith_sel = ALU_ADD;
        unique case (funct3_i)
            3'b000:  arith_sel = ALU_ADD;
            3'b001:  arith_sel = ALU_SLL;
            3'b010:  arith_sel = ALU_SLT;
            3'b011:  arith_sel = ALU_SLTU;
            3'b100:  arith_sel = ALU_XOR;
            3'b101:  arith_sel = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  arith_sel = ALU_OR;
            3'b111:  arith_sel = ALU_AND;
            default: arith_sel = ALU_ADD;
        endcase
    end

    // Immediate forms have no SUBI, so bit 30 only matters for R-type ADD/SUB.
    always_comb begin
        alu_sel_o = ALU_ADD;
        unique case (op_class_i)
            CLS_R:      alu_sel_o = (funct3_i == 3'b000 && funct7b5_i) ? ALU_SUB : arith_sel;
            CLS_I:      alu_sel_o = arith_sel;
            CLS_BRANCH: alu_sel_o = ALU_SUB;
            default:    alu_sel_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and selects, and counts retired instructions.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  resetPC,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  PCSrc,
    output logic                  IRWrite,
    output logic                  IorD,
    output logic                  ASel,
    output logic                  RegWEn,
    output logic                  MEMRead,
    output logic                  MEMWrite,
    output logic                  illegal,
    output logic                  retire,
    output logic [SEL_W-1:0]      BSel,
    output logic [ALUSEL_W-1:0]   ALUSel,
    output logic [SEL_W-1:0]      WBSel,
    output logic [STATE_W-1:0]    state_dbg,
    output logic [INSTRET_W-1:0]  instret
);

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    op_class_e              op_class;
    logic [ALUSEL_W-1:0]    alu_sel_dec;
    logic                   branch_taken;

    assign op_class     = classify(opcode, funct3);
    assign branch_taken = (funct3 == F3_BNE) ? !zero : zero;
    assign state_dbg    = STATE_W'(state_q);
    assign instret      = instret_q;

    alu_decoder u_alu_decoder (
        .op_class_i (op_class),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .alu_sel_o  (alu_sel_dec)
    );

    always_ff @(posedge CLK) begin
        if (resetPC) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next state and Moore/Mealy control outputs.
    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        ASel     = 1'b0;
        RegWEn   = 1'b0;
        MEMRead  = 1'b0;
        MEMWrite = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;
        BSel     = BSEL_RS2;
        ALUSel   = ALU_ADD;
        WBSel    = WBSEL_ALU;

        unique case (state_q)
            ST_FETCH: begin
                MEMRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form OldPC+imm so branch/JAL targets sit in ALUOut.
                ASel    = 1'b1;
                BSel    = BSEL_IMM;
                ALUSel  = ALU_ADD;
                state_d = (op_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                unique case (op_class)
                    CLS_R: begin
                        BSel    = BSEL_RS2;
                        ALUSel  = alu_sel_dec;
                        state_d = ST_WB;
                    end
                    CLS_I: begin
                        BSel    = BSEL_IMM;
                        ALUSel  = alu_sel_dec;
                        state_d = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        BSel    = BSEL_IMM;
                        ALUSel  = ALU_ADD;
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        BSel    = BSEL_RS2;
                        ALUSel  = alu_sel_dec;
                        PCWrite = branch_taken;
                        PCSrc   = branch_taken;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                        state_d = ST_WB;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                IorD = 1'b1;
                if (op_class == CLS_STORE) begin
                    MEMWrite = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    MEMRead = 1'b1;
                    if (mem_ready) state_d = ST_WB;
                end
            end
            ST_WB: begin
                RegWEn  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
                unique case (op_class)
                    CLS_LOAD: WBSel = WBSEL_MEM;
                    CLS_JAL:  WBSel = WBSEL_PC;
                    default:  WBSel = WBSEL_ALU;
                endcase
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset aborts whatever is in flight: nothing may commit in that cycle.
        if (resetPC) begin
            state_d  = ST_FETCH;
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            ASel     = 1'b0;
            RegWEn   = 1'b0;
            MEMRead  = 1'b0;
            MEMWrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
            BSel     = BSEL_RS2;
            ALUSel   = ALU_ADD;
            WBSel    = WBSEL_ALU;
        end

        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state/strobe checks against
// hand-derived sequences for each instruction class, reset and trap behaviour.
module tb_multicycle_controller;

    logic        CLK = 1'b0;
    logic        resetPC;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCSrc, IRWrite, IorD, ASel, RegWEn;
    logic        MEMRead, MEMWrite, illegal, retire;
    logic [1:0]  BSel;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel;
    logic [2:0]  state_dbg;
    logic [31:0] instret;
    logic [9:0]  strb;

    int checks   = 0;
    int failures = 0;

    // Strobe vector bit order: PCWrite PCSrc IRWrite IorD ASel RegWEn MEMRead MEMWrite illegal retire
    localparam logic [9:0] V_NONE    = 10'b0000000000;
    localparam logic [9:0] V_FETCH_W = 10'b0000001000;
    localparam logic [9:0] V_FETCH   = 10'b1010001000;
    localparam logic [9:0] V_DECODE  = 10'b0000100000;
    localparam logic [9:0] V_WB      = 10'b0000010001;
    localparam logic [9:0] V_BR_TK   = 10'b1100000001;
    localparam logic [9:0] V_BR_NT   = 10'b0000000001;
    localparam logic [9:0] V_JAL     = 10'b1100000000;
    localparam logic [9:0] V_LD      = 10'b0001001000;
    localparam logic [9:0] V_ST_W    = 10'b0001000100;
    localparam logic [9:0] V_ST      = 10'b0001000101;
    localparam logic [9:0] V_TRAP    = 10'b0000000010;

    assign strb = {PCWrite, PCSrc, IRWrite, IorD, ASel, RegWEn, MEMRead, MEMWrite, illegal, retire};

    multicycle_controller dut (
        .CLK       (CLK),
        .resetPC   (resetPC),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .ASel      (ASel),
        .RegWEn    (RegWEn),
        .MEMRead   (MEMRead),
        .MEMWrite  (MEMWrite),
        .illegal   (illegal),
        .retire    (retire),
        .BSel      (BSel),
        .ALUSel    (ALUSel),
        .WBSel     (WBSel),
        .state_dbg (state_dbg),
        .instret   (instret)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check current state and strobes, then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] v);
        #1;
        chk({tag, ".state"}, 32'(state_dbg), 32'(st));
        chk({tag, ".strb"}, 32'(strb), 32'(v));
        tick();
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5);
        opcode   = op;
        funct3   = f3;
        funct7b5 = b5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetPC   = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick();
        tick();
        chk("rst.state", 32'(state_dbg), 32'd0);
        chk("rst.strb", 32'(strb), 32'(V_NONE));
        chk("rst.instret", instret, 32'd0);
        resetPC = 1'b0;

        // R-type SUB
        cyc("sub.f", 3'd0, V_FETCH);
        #1;
        chk("sub.d.bsel", 32'(BSel), 32'h1);
        chk("sub.d.alusel", 32'(ALUSel), 32'h0);
        cyc("sub.d", 3'd1, V_DECODE);
        #1;
        chk("sub.e.alusel", 32'(ALUSel), 32'h1);
        chk("sub.e.bsel", 32'(BSel), 32'h0);
        cyc("sub.e", 3'd2, V_NONE);
        cyc("sub.w", 3'd4, V_WB);
        chk("sub.instret", instret, 32'd1);

        // LW with two wait cycles in FETCH and in MEM
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        cyc("lw.f0", 3'd0, V_FETCH_W);
        cyc("lw.f1", 3'd0, V_FETCH_W);
        mem_ready = 1'b1;
        cyc("lw.f2", 3'd0, V_FETCH);
        cyc("lw.d", 3'd1, V_DECODE);
        cyc("lw.e", 3'd2, V_NONE);
        mem_ready = 1'b0;
        cyc("lw.m0", 3'd3, V_LD);
        cyc("lw.m1", 3'd3, V_LD);
        mem_ready = 1'b1;
        cyc("lw.m2", 3'd3, V_LD);
        #1;
        chk("lw.wbsel", 32'(WBSel), 32'h1);
        cyc("lw.w", 3'd4, V_WB);
        chk("lw.back", 32'(state_dbg), 32'd0);
        chk("lw.instret", instret, 32'd2);

        // BEQ taken then not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        cyc("beq1.f", 3'd0, V_FETCH);
        cyc("beq1.d", 3'd1, V_DECODE);
        #1;
        chk("beq1.alusel", 32'(ALUSel), 32'h1);
        cyc("beq1.e", 3'd2, V_BR_TK);
        zero = 1'b0;
        cyc("beq0.f", 3'd0, V_FETCH);
        cyc("beq0.d", 3'd1, V_DECODE);
        cyc("beq0.e", 3'd2, V_BR_NT);
        chk("beq.instret", instret, 32'd4);

        // BNE taken when zero=0
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc("bne.f", 3'd0, V_FETCH);
        cyc("bne.d", 3'd1, V_DECODE);
        cyc("bne.e", 3'd2, V_BR_TK);

        // JAL
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal.f", 3'd0, V_FETCH);
        cyc("jal.d", 3'd1, V_DECODE);
        cyc("jal.e", 3'd2, V_JAL);
        #1;
        chk("jal.wbsel", 32'(WBSel), 32'h2);
        cyc("jal.w", 3'd4, V_WB);
        chk("jal.instret", instret, 32'd6);

        // ADDI with bit30 set stays ADD; SRAI selects SRA
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc("addi.f", 3'd0, V_FETCH);
        cyc("addi.d", 3'd1, V_DECODE);
        #1;
        chk("addi.alusel", 32'(ALUSel), 32'h0);
        chk("addi.bsel", 32'(BSel), 32'h1);
        cyc("addi.e", 3'd2, V_NONE);
        cyc("addi.w", 3'd4, V_WB);
        set_instr(7'b0010011, 3'b101, 1'b1);
        cyc("srai.f", 3'd0, V_FETCH);
        cyc("srai.d", 3'd1, V_DECODE);
        #1;
        chk("srai.alusel", 32'(ALUSel), 32'h7);
        cyc("srai.e", 3'd2, V_NONE);
        cyc("srai.w", 3'd4, V_WB);
        chk("alu.instret", instret, 32'd8);

        // Illegal opcode traps until reset
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc("ill.f", 3'd0, V_FETCH);
        cyc("ill.d", 3'd1, V_DECODE);
        for (int i = 0; i < 10; i++) cyc("trap", 3'd5, V_TRAP);
        chk("trap.instret", instret, 32'd8);
        resetPC = 1'b1;
        #1;
        chk("trap.rst.strb", 32'(strb), 32'(V_NONE));
        tick();
        resetPC = 1'b0;
        chk("trap.rst.state", 32'(state_dbg), 32'd0);
        chk("trap.rst.instret", instret, 32'd0);

        // instret wrap on a store retire
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("wrap.pre", instret, 32'hFFFF_FFFF);
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw.f", 3'd0, V_FETCH);
        cyc("sw.d", 3'd1, V_DECODE);
        cyc("sw.e", 3'd2, V_NONE);
        cyc("sw.m", 3'd3, V_ST);
        chk("sw.back", 32'(state_dbg), 32'd0);
        chk("wrap.instret", instret, 32'd0);

        // Reset during a store wait aborts with no write
        cyc("swa.f", 3'd0, V_FETCH);
        cyc("swa.d", 3'd1, V_DECODE);
        cyc("swa.e", 3'd2, V_NONE);
        mem_ready = 1'b0;
        cyc("swa.m0", 3'd3, V_ST_W);
        resetPC = 1'b1;
        #1;
        chk("swa.rst.strb", 32'(strb), 32'(V_NONE));
        tick();
        resetPC   = 1'b0;
        mem_ready = 1'b1;
        cyc("swa.after", 3'd0, V_FETCH);
        chk("swa.instret", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
